// File: rtl/pipe_decoder.sv
// pipe_decoder: registered code-to-vector decoder behind a two-entry
// (output register + skid register) elastic buffer, with a saturating
// count of illegal items accepted.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream code valid
//   in_ready   block can accept (registered, equals !skid_full)
//   in_code    code to decode (IN_W bits)
//   in_mode    00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved
//   out_valid  out_vec/out_err hold a valid item
//   out_ready  downstream accepts
//   out_vec    decoded vector (OUT_N bits), registered
//   out_err    decoded item was illegal, registered
//   err_cnt    saturating count of illegal items accepted (CNT_W bits)
module pipe_decoder #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_N = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out_vec,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    // One extra bit so OUT_N == 2**IN_W is representable in the legality compare.
    localparam int unsigned CMP_W = IN_W + 1;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_ALOW   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Skid register: holds the second item while the output register stalls.
    logic             sr_full;
    logic [OUT_N-1:0] sr_vec;
    logic             sr_err;

    logic             in_fire;
    logic             out_fire;

    logic [OUT_N-1:0] dec_vec;
    logic             dec_err;

    logic             or_full_n;
    logic [OUT_N-1:0] or_vec_n;
    logic             or_err_n;
    logic             sr_full_n;
    logic [OUT_N-1:0] sr_vec_n;
    logic             sr_err_n;
    logic [CNT_W-1:0] err_cnt_n;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Decode the incoming code; illegal items decode to all zeros.
    always_comb begin
        dec_vec = '0;
        dec_err = 1'b0;
        if ((in_mode == MODE_RSVD) || ({1'b0, in_code} >= CMP_W'(OUT_N))) begin
            dec_err = 1'b1;
        end else begin
            for (int unsigned i = 0; i < OUT_N; i++) begin
                case (in_mode)
                    MODE_ONEHOT: dec_vec[i] = (IN_W'(i) == in_code);
                    MODE_THERM:  dec_vec[i] = (IN_W'(i) <= in_code);
                    MODE_ALOW:   dec_vec[i] = (IN_W'(i) != in_code);
                    default:     dec_vec[i] = 1'b0;
                endcase
            end
        end
    end

    // Next-state for the output/skid registers and the error counter.
    always_comb begin
        or_full_n = out_valid;
        or_vec_n  = out_vec;
        or_err_n  = out_err;
        sr_full_n = sr_full;
        sr_vec_n  = sr_vec;
        sr_err_n  = sr_err;
        err_cnt_n = err_cnt;

        // Drain: the skid entry (if any) advances into the output register.
        if (out_fire) begin
            if (sr_full) begin
                or_vec_n  = sr_vec;
                or_err_n  = sr_err;
                sr_full_n = 1'b0;
            end else begin
                or_full_n = 1'b0;
            end
        end

        // Fill: the output register if it ends up empty this edge, else the skid.
        if (in_fire) begin
            if (!or_full_n) begin
                or_full_n = 1'b1;
                or_vec_n  = dec_vec;
                or_err_n  = dec_err;
            end else begin
                sr_full_n = 1'b1;
                sr_vec_n  = dec_vec;
                sr_err_n  = dec_err;
            end
            if (dec_err && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt_n = err_cnt + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_err   <= 1'b0;
            sr_full   <= 1'b0;
            sr_vec    <= '0;
            sr_err    <= 1'b0;
            in_ready  <= 1'b1;
            err_cnt   <= '0;
        end else begin
            out_valid <= or_full_n;
            out_vec   <= or_vec_n;
            out_err   <= or_err_n;
            sr_full   <= sr_full_n;
            sr_vec    <= sr_vec_n;
            sr_err    <= sr_err_n;
            in_ready  <= !sr_full_n;
            err_cnt   <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_pipe_decoder.sv
// Self-checking bench for pipe_decoder. Two instances share one input stream:
// a default build (8 outputs, 8-bit counter) and a narrow build (6 outputs,
// 2-bit counter). A queue-based reference model predicts both.
module tb_pipe_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic [1:0] in_mode;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_vec;
    logic       out_err;
    logic [7:0] err_cnt;

    logic       in_ready6;
    logic       out_valid6;
    logic [5:0] out_vec6;
    logic       out_err6;
    logic [1:0] err_cnt6;

    pipe_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    pipe_decoder #(.IN_W(3), .OUT_N(6), .CNT_W(2)) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready6),
        .in_code  (in_code),
        .in_mode  (in_mode),
        .out_valid(out_valid6),
        .out_ready(out_ready),
        .out_vec  (out_vec6),
        .out_err  (out_err6),
        .err_cnt  (err_cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: items held in the block, oldest first, as {err, vec[7:0]}.
    logic [8:0] q8[$];
    logic [8:0] q6[$];
    int         cnt8 = 0;
    int         cnt2 = 0;
    logic       acc  = 1'b0;

    // Observed state, data masked to zero when nothing is presented.
    logic [18:0] obs8;
    logic [12:0] obs6;
    assign obs8 = {out_valid, in_ready, out_valid ? {out_err, out_vec} : 9'd0, err_cnt};
    assign obs6 = {out_valid6, in_ready6, out_valid6 ? {out_err6, 2'b00, out_vec6} : 9'd0, err_cnt6};

    function automatic logic [8:0] model_dec(input int code, input int mode, input int n);
        int full;
        if (mode == 3 || code >= n) return 9'h100;
        full = (1 << n) - 1;
        case (mode)
            0:       return 9'(1 << code);
            1:       return 9'((2 << code) - 1);
            default: return 9'(~(1 << code) & full);
        endcase
    endfunction

    function automatic logic [18:0] exp8();
        return {q8.size() != 0, q8.size() < 2, (q8.size() != 0) ? q8[0] : 9'd0, 8'(cnt8)};
    endfunction

    function automatic logic [12:0] exp6();
        return {q6.size() != 0, q6.size() < 2, (q6.size() != 0) ? q6[0] : 9'd0, 2'(cnt2)};
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, and
    // return at the following falling edge where outputs are sampled.
    task automatic cycle(input logic v, input logic [2:0] c, input logic [1:0] m,
                         input logic ordy, input logic rn);
        logic [8:0] d8;
        logic [8:0] d6;
        in_valid  = v;
        in_code   = c;
        in_mode   = m;
        out_ready = ordy;
        rst_n     = rn;
        @(posedge clk);
        if (!rn) begin
            q8.delete();
            q6.delete();
            cnt8 = 0;
            cnt2 = 0;
            acc  = 1'b0;
        end else begin
            acc = v && (q8.size() < 2);
            if (q8.size() != 0 && ordy) begin
                void'(q8.pop_front());
                void'(q6.pop_front());
            end
            if (acc) begin
                d8 = model_dec(int'(c), int'(m), 8);
                d6 = model_dec(int'(c), int'(m), 6);
                q8.push_back(d8);
                q6.push_back(d6);
                if (d8[8] && cnt8 < 255) cnt8++;
                if (d6[8] && cnt2 < 3) cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle($urandom_range(0, 1), 3'($urandom), 2'($urandom), 1'b1, 1'b0);
            vectors++;
            if ({out_valid, in_ready, out_err, out_vec, err_cnt} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
                miscompares++;
                $display("FAIL reset dut8: got v=%b r=%b e=%b vec=%h cnt=%0d want v=0 r=1 e=0 vec=00 cnt=0",
                         out_valid, in_ready, out_err, out_vec, err_cnt);
            end
            vectors++;
            if ({out_valid6, in_ready6, out_err6, out_vec6, err_cnt6} !== {1'b0, 1'b1, 1'b0, 6'h00, 2'd0}) begin
                miscompares++;
                $display("FAIL reset dut6: got v=%b r=%b e=%b vec=%h cnt=%0d want v=0 r=1 e=0 vec=00 cnt=0",
                         out_valid6, in_ready6, out_err6, out_vec6, err_cnt6);
            end
        end
    endtask

    task automatic test_onehot_seq();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 2'b00, 1'b1, 1'b1);
            want = 8'd1 << i;
            vectors++;
            if ({out_valid, out_err, out_vec} !== {1'b1, 1'b0, want}) begin
                miscompares++;
                $display("FAIL onehot[%0d]: got v=%b e=%b vec=%h want v=1 e=0 vec=%h",
                         i, out_valid, out_err, out_vec, want);
            end
            vectors++;
            if (obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL onehot6[%0d]: got %h want %h", i, obs6, exp6());
            end
        end
        cycle(1'b0, 3'd0, 2'b00, 1'b1, 1'b1);
        vectors++;
        if (obs8 !== exp8()) begin
            miscompares++;
            $display("FAIL onehot_idle: got %h want %h", obs8, exp8());
        end
    endtask

    task automatic test_modes();
        logic [2:0] codes[3];
        logic [1:0] modes[3];
        logic [7:0] vecs[3];
        logic       errs[3];
        codes = '{3'd3, 3'd3, 3'd2};
        modes = '{2'b01, 2'b10, 2'b11};
        vecs  = '{8'h0F, 8'hF7, 8'h00};
        errs  = '{1'b0, 1'b0, 1'b1};
        cycle(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, codes[i], modes[i], 1'b1, 1'b1);
            vectors++;
            if ({out_valid, out_err, out_vec, err_cnt} !== {1'b1, errs[i], vecs[i], 8'(errs[i])}) begin
                miscompares++;
                $display("FAIL mode[%0d]: got v=%b e=%b vec=%h cnt=%0d want v=1 e=%b vec=%h cnt=%0d",
                         i, out_valid, out_err, out_vec, err_cnt, errs[i], vecs[i], errs[i]);
            end
            vectors++;
            if (obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL mode6[%0d]: got %h want %h", i, obs6, exp6());
            end
        end
    endtask

    task automatic test_narrow();
        cycle(1'b1, 3'd6, 2'b00, 1'b1, 1'b1);
        vectors++;
        if ({out_valid6, out_err6, out_vec6} !== {1'b1, 1'b1, 6'h00}) begin
            miscompares++;
            $display("FAIL narrow_code6: got v=%b e=%b vec=%h want v=1 e=1 vec=00",
                     out_valid6, out_err6, out_vec6);
        end
        cycle(1'b1, 3'd5, 2'b00, 1'b1, 1'b1);
        vectors++;
        if ({out_valid6, out_err6, out_vec6} !== {1'b1, 1'b0, 6'h20}) begin
            miscompares++;
            $display("FAIL narrow_code5: got v=%b e=%b vec=%h want v=1 e=0 vec=20",
                     out_valid6, out_err6, out_vec6);
        end
        vectors++;
        if (obs8 !== exp8()) begin
            miscompares++;
            $display("FAIL narrow_dut8: got %h want %h", obs8, exp8());
        end
    endtask

    task automatic test_err_sat();
        int want;
        cycle(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 3'($urandom), 2'b11, 1'b1, 1'b1);
            want = (k + 1 < 3) ? k + 1 : 3;
            vectors++;
            if (int'(err_cnt6) != want || obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL err_sat[%0d]: got cnt=%0d obs=%h want cnt=%0d obs=%h",
                         k, err_cnt6, obs6, want, exp6());
            end
            vectors++;
            if (int'(err_cnt) != k + 1) begin
                miscompares++;
                $display("FAIL err_cnt8[%0d]: got %0d want %0d", k, err_cnt, k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] codes[3];
        int idx;
        codes = '{3'd1, 3'd2, 3'd4};
        idx = 0;
        cycle(1'b0, 3'd0, 2'b00, 1'b1, 1'b1);
        cycle(1'b0, 3'd0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, codes[idx], 2'b00, 1'b0, 1'b1);
            if (acc) idx++;
            vectors++;
            if (obs8 !== exp8() || obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %h/%h want %h/%h", i, obs8, obs6, exp8(), exp6());
            end
        end
        vectors++;
        if (idx != 2 || in_ready !== 1'b0 || out_vec !== 8'h02) begin
            miscompares++;
            $display("FAIL bp_full: got accepted=%0d in_ready=%b vec=%h want accepted=2 in_ready=0 vec=02",
                     idx, in_ready, out_vec);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(idx < 3, codes[(idx < 3) ? idx : 2], 2'b00, 1'b1, 1'b1);
            if (acc) idx++;
            vectors++;
            if (obs8 !== exp8() || obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL bp_release[%0d]: got %h/%h want %h/%h", i, obs8, obs6, exp8(), exp6());
            end
        end
        vectors++;
        if (idx != 3 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drained: got accepted=%0d out_valid=%b want accepted=3 out_valid=0", idx, out_valid);
        end
    endtask

    task automatic test_random();
        logic rn;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 63) != 0);
            cycle($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), $urandom_range(0, 2) != 0, rn);
            vectors++;
            if (obs8 !== exp8()) begin
                miscompares++;
                $display("FAIL random8[%0d]: got %h want %h", i, obs8, exp8());
            end
            vectors++;
            if (obs6 !== exp6()) begin
                miscompares++;
                $display("FAIL random6[%0d]: got %h want %h", i, obs6, exp6());
            end
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, 3'd6, 2'b11, 1'b0, 1'b1);
        cycle(1'b1, 3'd5, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 3'd4, 2'b00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_fill: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
        end
        cycle(1'b1, 3'd3, 2'b00, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, in_ready, err_cnt, out_vec} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b r=%b cnt=%0d vec=%h want v=0 r=1 cnt=0 vec=00",
                     out_valid, in_ready, err_cnt, out_vec);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'($urandom), 2'($urandom), 1'b1, 1'b1);
            vectors++;
            if (obs8 !== exp8() || obs6 !== exp6() || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_stale[%0d]: got %h/%h want %h/%h", i, obs8, obs6, exp8(), exp6());
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_onehot_seq();
        test_modes();
        test_narrow();
        test_err_sat();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_decoder.md
PIPE_DECODER -- requirements
Module: pipe_decoder

Interface
REQ-001 Parameter IN_W, default 3: code width in bits, legal range 1..7.
REQ-002 Parameter OUT_N, default 8: output vector width, legal range 2..2**IN_W.
REQ-003 Parameter CNT_W, default 8: error-counter width.
REQ-004 Port list:
- clk  input  1: sole clock, rising edge.
- rst_n  input  1: synchronous active-low reset.
- in_valid  input  1: upstream code valid.
- in_ready  output  1: block can accept; driven directly from a register.
- in_code  input  IN_W: code to decode.
- in_mode  input  2: 00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved.
- out_valid  output  1: out_vec/out_err valid.
- out_ready  input  1: downstream accepts.
- out_vec  output  OUT_N: decoded vector.
- out_err  output  1: decoded item was illegal.
- err_cnt  output  CNT_W: saturating count of illegal items accepted.
REQ-005 All ports shall be single-clock-domain; clk and rst_n shall be the only clock and reset.

Function
REQ-006 Input transfer occurs when in_valid && in_ready at a clk edge; output transfer occurs when out_valid && out_ready.
REQ-007 Decode rules, per bit i in 0..OUT_N-1:
- mode 00: out_vec[i] = (i == in_code).
- mode 01: out_vec[i] = (i <= in_code).
- mode 10: out_vec[i] = (i != in_code).
REQ-008 An item is illegal when in_code >= OUT_N or in_mode == 11; illegal items shall produce out_vec = all zeros and out_err = 1.
REQ-009 Legal items shall produce out_err = 0.
REQ-010 Decoding shall be computed at input transfer and stored; out_vec/out_err shall be register outputs.
REQ-011 Structure: one output register (OR) plus one skid register (SR), each with a full flag.
REQ-012 in_ready shall equal !SR_full, registered.
REQ-013 On input transfer: if OR is empty, or OR is draining this cycle and SR is empty, the item loads OR; otherwise it loads SR.
REQ-014 On output transfer with SR full, SR shall move to OR in the same edge, and SR becomes empty unless a simultaneous input transfer refills it.
REQ-015 Latency: an item accepted at edge k shall be presented (out_valid = 1) after edge k when OR was empty.
REQ-016 Throughput: one item per cycle sustained while out_ready = 1.
REQ-017 Ordering shall be strictly FIFO; no item shall be dropped or duplicated.
REQ-018 OR contents shall remain stable while out_valid && !out_ready.
REQ-019 With both OR and SR full, in_ready = 0; the first out_ready edge shall free SR and set in_ready = 1 on the following cycle.
REQ-020 err_cnt shall increment by 1 on each input transfer of an illegal item and saturate at 2**CNT_W-1.
REQ-021 err_cnt shall not change on legal items or at output transfer.
REQ-022 in_code and in_mode shall be ignored when in_valid = 0.

Reset
REQ-023 While rst_n = 0 at a clk edge:
- out_valid = 0, in_ready = 1, out_vec = 0, out_err = 0, err_cnt = 0.
- OR and SR shall be emptied.
REQ-024 Reset asserted mid-stream shall discard all held items; no transfer shall be reported in the reset cycle.
REQ-025 The first input transfer shall be possible at the first edge with rst_n = 1.

Verification
REQ-026 Defaults, out_ready = 1, mode 00, codes 0..7 back-to-back -> out_vec 0x01,0x02,...,0x80, one per cycle, 1-cycle latency, out_err = 0.
REQ-027 Mode 01, code 3 -> 0x0F; mode 10, code 3 -> 0xF7; mode 11, code 2 -> 0x00, out_err = 1, err_cnt = 1.
REQ-028 OUT_N = 6, IN_W = 3, code 6 -> out_vec = 0, out_err = 1; code 5 mode 00 -> 0x20.
REQ-029 Backpressure, out_ready = 0 and three items offered -> two accepted, in_ready = 0; release out_ready -> items emerge in order, third item accepted, none lost.
REQ-030 CNT_W = 2, five illegal items -> err_cnt reads 1,2,3,3,3.
REQ-031 rst_n = 0 with OR and SR full -> next cycle out_valid = 0, in_ready = 1, err_cnt = 0, and no stale item appears afterwards.
